// File: rtl/bloom_pkg.sv
// Shared types and sizing helpers for the bloom table write controller.
package bloom_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} state_e;

  function automatic int len_cnt(input int min_s, input int max_s);
    return max_s - min_s + 1;
  endfunction

  // Never narrower than one bit, so a single-bank build still has a legal port.
  function automatic int len_idx_w(input int min_s, input int max_s);
    int c;
    c = len_cnt(min_s, max_s);
    return (c > 1) ? $clog2(c) : 1;
  endfunction
endpackage

// File: rtl/bloom_setting_if.sv
// Settings/command bundle between the application and the bloom table write controller.
interface bloom_setting_if #(
  parameter int LEN_W      = 8,
  parameter int HASH_CNT   = 10,
  parameter int HASH_WIDTH = 12
) ();
  logic [LEN_W-1:0]                     str_len;
  logic [HASH_CNT-1:0][HASH_WIDTH-1:0]  hash;
  logic [HASH_CNT-1:0]                  hash_mask_val;
  logic                                 wr_data;
  logic                                 wr_stb;
  logic                                 full_clr_stb;
  logic                                 ready;
  logic                                 full_clr_done;

  modport app  (input str_len, hash, hash_mask_val, wr_data, wr_stb, full_clr_stb,
                output ready, full_clr_done);
  modport host (output str_len, hash, hash_mask_val, wr_data, wr_stb, full_clr_stb,
                input ready, full_clr_done);
endinterface

// File: rtl/bloom_clr_cnt.sv
// Nested clear counter: address is the inner count, length bank the outer one.
module bloom_clr_cnt #(
  parameter int ADDR_W   = 12,
  parameter int BANK_W   = 5,
  parameter int BANK_CNT = 29
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic [BANK_W-1:0] bank,
  output logic              last
);
  localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(BANK_CNT - 1);

  assign last = (addr == '1) && (bank == BANK_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr <= '0;
      bank <= '0;
    end else if (start) begin
      addr <= '0;
      bank <= '0;
    end else if (enable) begin
      if (addr == '1) begin
        addr <= '0;
        bank <= (bank == BANK_MAX) ? '0 : bank + 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/bloom_table_wr_ctrl.sv
// Bloom table write controller: single-bit inserts/removes and a full-table clear sweep.
// Define BLOOM_CLR_ON_RESET_EN to run a full clear automatically after reset release.
module bloom_table_wr_ctrl
  import bloom_pkg::*;
#(
  parameter int MIN_S      = 4,
  parameter int MAX_S      = 32,
  parameter int HASH_CNT   = 10,
  parameter int HASH_WIDTH = 12
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  bloom_setting_if.app                          settings,
  output logic [HASH_CNT-1:0]                   mem_wr_en_o,
  output logic [len_idx_w(MIN_S, MAX_S)-1:0]    mem_wr_len_o,
  output logic [HASH_CNT-1:0][HASH_WIDTH-1:0]   mem_wr_addr_o,
  output logic                                  mem_wr_data_o,
  output logic                                  err_len_o
);
  localparam int LW = len_idx_w(MIN_S, MAX_S);
  localparam int LC = len_cnt(MIN_S, MAX_S);

  state_e                              state_q, state_d;
  logic                                init_pend;
  logic                                ready, clr_go, wr_acc, in_range;
  logic                                clr_last, done_q;
  logic [HASH_WIDTH-1:0]               clr_addr;
  logic [LW-1:0]                       clr_bank;
  logic [HASH_CNT-1:0][HASH_WIDTH-1:0] hash_q;
  logic [HASH_CNT-1:0]                 mask_q;
  logic [LW-1:0]                       len_idx_q;
  logic                                len_ok_q, data_q;

`ifdef BLOOM_CLR_ON_RESET_EN
  // Held until the post-reset clear has been launched; keeps ready low meanwhile.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    init_pend <= 1'b1;
    else if (clr_go) init_pend <= 1'b0;
  end
`else
  assign init_pend = 1'b0;
`endif

  assign ready    = (state_q == ST_IDLE) && !init_pend;
  assign clr_go   = (ready && settings.full_clr_stb) || ((state_q == ST_IDLE) && init_pend);
  assign wr_acc   = ready && settings.wr_stb && !settings.full_clr_stb;
  assign in_range = (int'(settings.str_len) >= MIN_S) && (int'(settings.str_len) <= MAX_S);

  assign settings.ready         = ready;
  assign settings.full_clr_done = done_q;

  bloom_clr_cnt #(.ADDR_W(HASH_WIDTH), .BANK_W(LW), .BANK_CNT(LC)) u_clr_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (clr_go),
    .enable  (state_q == ST_CLEAR),
    .addr    (clr_addr),
    .bank    (clr_bank),
    .last    (clr_last)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_go) state_d = ST_CLEAR;
                else if (wr_acc) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hash_q    <= '0;
      mask_q    <= '0;
      len_idx_q <= '0;
      len_ok_q  <= 1'b0;
      data_q    <= 1'b0;
    end else if (wr_acc) begin
      hash_q    <= settings.hash;
      mask_q    <= settings.hash_mask_val;
      len_idx_q <= in_range ? LW'(int'(settings.str_len) - MIN_S) : '0;
      len_ok_q  <= in_range;
      data_q    <= settings.wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_len_o <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if ((state_q == ST_CLEAR) && clr_last) err_len_o <= 1'b0;
      else if (wr_acc && !in_range)          err_len_o <= 1'b1;
      if (clr_go)                                 done_q <= 1'b0;
      else if ((state_q == ST_CLEAR) && clr_last) done_q <= 1'b1;
    end
  end

  always_comb begin
    mem_wr_en_o   = '0;
    mem_wr_len_o  = '0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = 1'b0;
    case (state_q)
      ST_WRITE: begin
        mem_wr_en_o   = len_ok_q ? mask_q : '0;
        mem_wr_len_o  = len_idx_q;
        mem_wr_addr_o = hash_q;
        mem_wr_data_o = data_q;
      end
      ST_CLEAR: begin
        mem_wr_en_o  = '1;
        mem_wr_len_o = clr_bank;
        for (int i = 0; i < HASH_CNT; i++) mem_wr_addr_o[i] = clr_addr;
      end
      default: ;
    endcase
  end
endmodule
